pia_routing_config_writer: RTL and testbench

Serial loader that produces the 144-bit routing configuration consumed by the PIA-to-LAB signal selector. Accepts a bit stream over a valid/ready handshake, shifts it into a shadow register, checks an odd-parity trailer bit, and only then commits the word to the active configuration output. The selector therefore never sees a partial or corrupt routing word. It sits between the device programming (ISP) front end and one LAB's PIA selector.

---
 rtl/pia_config_pkg.sv | 16 +
 rtl/pia_routing_config_writer_if.sv | 53 +++++
 rtl/pia_config_shift_register.sv | 36 +++
 rtl/pia_routing_config_writer.sv | 141 ++++++++++++++
 tb/tb_pia_routing_config_writer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pia_config_pkg.sv
// pia_config_pkg
// Shared definitions for the PIA routing configuration loader: the routing
// word width consumed by the PIA-to-LAB selector, the bit-counter width
// derived from it, and the loader state encoding.
package pia_config_pkg;

    localparam int PIA_TO_LAB_ROUTING_BIT_COUNT = 144;
    localparam int CNT_W = $clog2(PIA_TO_LAB_ROUTING_BIT_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/pia_routing_config_writer_if.sv
// pia_routing_config_writer_if
// Groups the serial load handshake and the configuration outputs of the
// routing configuration loader.
//   load_start          master->slave  one-cycle request to (re)start a load
//   serial_data         master->slave  configuration / parity bit
//   serial_valid        master->slave  serial_data is valid
//   serial_ready        slave->master  loader accepts a bit this cycle
//   configuration       slave->master  active routing word for the selector
//   configuration_valid slave->master  configuration holds a committed word
//   busy                slave->master  load in progress
//   load_done           slave->master  one-cycle pulse on commit
//   parity_error        slave->master  sticky, last load failed parity
interface pia_routing_config_writer_if
    import pia_config_pkg::*;
#(
    parameter int BIT_COUNT = PIA_TO_LAB_ROUTING_BIT_COUNT
);

    logic                 load_start;
    logic                 serial_data;
    logic                 serial_valid;
    logic                 serial_ready;
    logic [BIT_COUNT-1:0] configuration;
    logic                 configuration_valid;
    logic                 busy;
    logic                 load_done;
    logic                 parity_error;

    modport master (
        output load_start,
        output serial_data,
        output serial_valid,
        input  serial_ready,
        input  configuration,
        input  configuration_valid,
        input  busy,
        input  load_done,
        input  parity_error
    );

    modport slave (
        input  load_start,
        input  serial_data,
        input  serial_valid,
        output serial_ready,
        output configuration,
        output configuration_valid,
        output busy,
        output load_done,
        output parity_error
    );

endinterface

// File: rtl/pia_config_shift_register.sv
// pia_config_shift_register
// Shadow register for an incoming routing word plus a running XOR of every
// bit shifted in. Bits enter at the MSB and move toward the LSB, so after
// WIDTH shifts the first bit received sits in shadow[0].
//   clock, reset  system clock, async active-high reset
//   clear         zero shadow and accumulator (wins over shift_en)
//   shift_en      shift bit_in into the MSB and fold it into the accumulator
//   bit_in        incoming serial bit
//   shadow        assembled word
//   parity_acc    XOR of all bits shifted in since the last clear
module pia_config_shift_register #(
    parameter int WIDTH = 144
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] shadow,
    output logic             parity_acc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            parity_acc <= 1'b0;
        end else if (clear) begin
            shadow     <= '0;
            parity_acc <= 1'b0;
        end else if (shift_en) begin
            shadow     <= {bit_in, shadow[WIDTH-1:1]};
            parity_acc <= parity_acc ^ bit_in;
        end
    end

endmodule

// File: rtl/pia_routing_config_writer.sv
// pia_routing_config_writer
// Serially loads a routing word into a shadow register, checks an odd
// parity trailer bit, and only then commits the word to the selector, so
// the selector never sees a partial or corrupt word.
//   clock  system clock, rising edge
//   reset  async active-high reset; clears every output including a
//          previously committed configuration
//   bus    pia_routing_config_writer_if.slave (handshake + config outputs)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no load in progress, serial_ready low
// SHIFT  | accepting routing bits, counter tracks bits received
// PARITY | all routing bits in, waiting for the odd parity trailer bit
module pia_routing_config_writer
    import pia_config_pkg::*;
(
    input  logic                               clock,
    input  logic                               reset,
    pia_routing_config_writer_if.slave         bus
);

    localparam int                BIT_COUNT = PIA_TO_LAB_ROUTING_BIT_COUNT;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BIT_COUNT - 1);

    cfg_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 perr_q;
    logic                 cfg_valid_q;
    logic [BIT_COUNT-1:0] cfg_q;

    logic                 xfer;
    logic                 clear;
    logic                 shift_en;
    logic                 commit;
    logic                 fail;
    logic [BIT_COUNT-1:0] shadow;
    logic                 parity_acc;

    pia_config_shift_register #(
        .WIDTH (BIT_COUNT)
    ) u_shift (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .shift_en   (shift_en),
        .bit_in     (bus.serial_data),
        .shadow     (shadow),
        .parity_acc (parity_acc)
    );

    // load_start is checked before any transfer in every state so that a
    // restart discards a bit offered in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear    = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        fail     = 1'b0;
        xfer     = bus.serial_valid && ready_q;

        if (bus.load_start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (xfer) begin
                        shift_en = 1'b1;
                        // Counter holds at the last index instead of
                        // stepping past it, so it can never wrap.
                        if (cnt_q == LAST_BIT) begin
                            state_d = PARITY;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        state_d = IDLE;
                        if (parity_acc ^ bus.serial_data) begin
                            commit = 1'b1;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ready/busy are registered from the next state so no input reaches an
    // output combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= commit;
            if (clear) begin
                perr_q <= 1'b0;
            end else if (fail) begin
                perr_q <= 1'b1;
            end
            if (commit) begin
                cfg_q       <= shadow;
                cfg_valid_q <= 1'b1;
            end
        end
    end

    assign bus.serial_ready        = ready_q;
    assign bus.busy                = busy_q;
    assign bus.load_done           = done_q;
    assign bus.parity_error        = perr_q;
    assign bus.configuration       = cfg_q;
    assign bus.configuration_valid = cfg_valid_q;

endmodule

// File: tb/tb_pia_routing_config_writer.sv
// Self-checking bench for pia_routing_config_writer. The reference model
// keeps only the committed word, its valid flag and the sticky parity
// error, updated from whole streams: a load passes when the total number
// of ones over routing bits plus trailer is odd.
module tb_pia_routing_config_writer;
    import pia_config_pkg::*;

    localparam int N = PIA_TO_LAB_ROUTING_BIT_COUNT;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int edges_at_commit = 0;

    logic [N-1:0] exp_cfg   = '0;
    logic         exp_valid = 1'b0;
    logic         exp_perr  = 1'b0;

    pia_routing_config_writer_if bus ();

    pia_routing_config_writer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [N-1:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(1, 0));
        return w;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic check_model(input string tag);
        chkw({tag, "_cfg"}, bus.configuration, exp_cfg);
        chk1({tag, "_valid"}, bus.configuration_valid, exp_valid);
        chk1({tag, "_perr"}, bus.parity_error, exp_perr);
    endtask

    task automatic start_load(input logic with_valid);
        bus.load_start   = 1'b1;
        bus.serial_valid = with_valid;
        bus.serial_data  = 1'($urandom_range(1, 0));
        step();
        bus.load_start   = 1'b0;
        bus.serial_valid = 1'b0;
        exp_perr = 1'b0;
        chk1("start_busy", bus.busy, 1'b1);
        chk1("start_ready", bus.serial_ready, 1'b1);
        chk1("start_perr", bus.parity_error, 1'b0);
    endtask

    task automatic send_bit(input logic b, input logic bubbles);
        logic done;
        logic rdy;
        logic vld;
        int   guard;
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 64) begin
            vld = bubbles ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.serial_valid = vld;
            bus.serial_data  = vld ? b : 1'($urandom_range(1, 0));
            rdy = bus.serial_ready;
            step();
            if (vld && rdy) done = 1'b1;
            guard++;
        end
        bus.serial_valid = 1'b0;
        chk1("xfer_accepted", done, 1'b1);
    endtask

    task automatic send_word(input logic [N-1:0] w, input int nbits, input logic bubbles);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[i], bubbles);
            chk1("stray_done", bus.load_done, 1'b0);
        end
    endtask

    task automatic finish_load(input logic [N-1:0] w, input logic pbit, input logic bubbles, input string tag);
        logic pass;
        send_bit(pbit, bubbles);
        edges_at_commit = edges;
        pass = (($countones(w) + int'(pbit)) % 2) == 1;
        if (pass) begin
            exp_cfg   = w;
            exp_valid = 1'b1;
        end else begin
            exp_perr  = 1'b1;
        end
        check_model(tag);
        chk1({tag, "_done"}, bus.load_done, pass);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_ready"}, bus.serial_ready, 1'b0);
        step();
        chk1({tag, "_done_once"}, bus.load_done, 1'b0);
        check_model({tag, "_hold"});
    endtask

    initial begin
        logic [N-1:0] w1;
        logic [N-1:0] w;
        logic [N-1:0] ones;

        bus.load_start   = 1'b0;
        bus.serial_valid = 1'b0;
        bus.serial_data  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check_model("reset");
        chk1("reset_ready", bus.serial_ready, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_done", bus.load_done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // serial_valid toggling in IDLE is ignored.
        for (int i = 0; i < 12; i++) begin
            bus.serial_valid = 1'($urandom_range(1, 0));
            bus.serial_data  = 1'($urandom_range(1, 0));
            step();
            chk1("idle_ready", bus.serial_ready, 1'b0);
            chk1("idle_busy", bus.busy, 1'b0);
            check_model("idle");
        end
        bus.serial_valid = 1'b0;

        // Pattern bit i = (i mod 3 == 0), correct parity, gapless.
        for (int i = 0; i < N; i++) w1[i] = ((i % 3) == 0);
        edges = 0;
        start_load(1'b0);
        send_word(w1, N, 1'b0);
        finish_load(w1, good_par(w1), 1'b0, "pat");
        chki("pat_latency", edges_at_commit, 146);
        chk1("pat_bit0", bus.configuration[0], 1'b1);
        chk1("pat_bit1", bus.configuration[1], 1'b0);
        chk1("pat_bit3", bus.configuration[3], 1'b1);

        // Same stream, inverted parity.
        start_load(1'b0);
        send_word(w1, N, 1'b0);
        finish_load(w1, ~good_par(w1), 1'b0, "badpar");

        // All ones with bubbles; 144 ones so trailer must be 1.
        ones = '1;
        start_load(1'b0);
        send_word(ones, N, 1'b1);
        finish_load(ones, 1'b1, 1'b1, "ones");

        // Restart after 70 bits, with a bit offered in the restart cycle.
        w = rand_word();
        start_load(1'b0);
        send_word(rand_word(), 70, 1'b0);
        start_load(1'b1);
        check_model("restart");
        w = rand_word();
        send_word(w, N, 1'b0);
        check_model("restart_old_held");
        finish_load(w, good_par(w), 1'b0, "restart");

        // Random words, random parity correctness, random bubbles.
        for (int k = 0; k < 4; k++) begin
            w = rand_word();
            start_load(1'b0);
            send_word(w, N, 1'b1);
            finish_load(w, good_par(w) ^ 1'($urandom_range(1, 0)), 1'b1, "rand");
        end

        // Reset while waiting for the parity bit.
        w = rand_word();
        w[0] = 1'b1;
        start_load(1'b0);
        send_word(w, N, 1'b0);
        finish_load(w, good_par(w), 1'b0, "prereset");
        start_load(1'b0);
        send_word(rand_word(), N, 1'b0);
        chk1("parity_busy", bus.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_cfg   = '0;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        check_model("midreset");
        chk1("midreset_ready", bus.serial_ready, 1'b0);
        chk1("midreset_busy", bus.busy, 1'b0);
        chk1("midreset_done", bus.load_done, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step();
        check_model("postreset");
        chk1("postreset_busy", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
